instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Upstream controller for the 32-bit synchronous-read instruction memory. It clears the memory, loads a program from a host stream through the memory write port, then runs the PC and fetches one word per cycle into the IF/ID boundary. It supports stall, branch redirect and halt. It is the only master of the memory's address, rw, reset and write-data ports.

Parameters:
PC_SIZE, 10, width of PC and memory addresses
INSTRUCTION_LENGTH, 32, instruction word width
MEM_DEPTH, 100, number of valid memory words (must be <= 2^PC_SIZE)
RESET_PC, 0, first fetch address after load

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
load_valid  in  1  host presents a program word
load_data  in  INSTRUCTION_LENGTH  program word
load_last  in  1  marks the final program word
load_ready  out  1  block accepts load words
stall  in  1  downstream cannot take the IF word this cycle
redirect  in  1  branch/jump taken; current IF word is wrong-path
redirect_pc  in  PC_SIZE  redirect target
mem_read_address  out  PC_SIZE  to memory read_address
mem_write_address  out  PC_SIZE  to memory write_address
mem_rw  out  1  1 = read, 0 = write
mem_reset_memory  out  1  synchronous clear request to memory
mem_instruction_in  out  INSTRUCTION_LENGTH  write data to memory
mem_instruction_out  in  INSTRUCTION_LENGTH  registered read data from memory
if_valid  out  1  IF word valid
if_pc  out  PC_SIZE  address of the IF word
if_instruction  out  INSTRUCTION_LENGTH  IF word, passed through from mem_instruction_out
halted  out  1  fetch stopped

Behaviour:
- Single clock domain; reset_n is asynchronous assert and synchronous release.
- Registers: state, pc, req_pc, req_valid, load_count.
- Reset values: state=CLEAR, pc=RESET_PC, req_pc=0, req_valid=0, load_count=0.
- Outputs during reset: mem_reset_memory=1, mem_rw=1, load_ready=0, if_valid=0, if_pc=0, halted=0, both mem addresses=0, mem_instruction_in=0.
- States: CLEAR, LOAD, RUN, HALT.
- CLEAR: mem_reset_memory=1 for exactly one cycle after reset release, then LOAD.
- LOAD:
  - load_ready=1.
  - mem_rw=0 only in a handshake cycle (load_valid & load_ready). Otherwise mem_rw=1, because the memory writes on every rw=0 edge.
  - mem_write_address=load_count; mem_instruction_in=load_data.
  - On handshake: load_count+1.
  - Exit to RUN when the handshake carries load_last, or load_count==MEM_DEPTH-1. On exit: pc=RESET_PC, req_valid=0.
- RUN:
  - mem_rw=1; load_ready=0.
  - Memory read latency is 1 cycle: the word at req_pc is on mem_instruction_out the cycle after req_pc is issued.
  - if_valid = req_valid & ~redirect; if_pc = req_pc.
  - Normal (no stall, no redirect, pc < MEM_DEPTH): mem_read_address=pc. At the edge: req_pc<=pc, req_valid<=1, pc<=pc+1.
  - Stall (no redirect): mem_read_address=req_pc (re-read the same word). pc, req_pc and req_valid hold, so if_* stay stable.
  - Redirect (overrides stall): mem_read_address=redirect_pc. At the edge: req_pc<=redirect_pc, req_valid<=1, pc<=redirect_pc+1. No bubble beyond the squashed cycle.
  - Redirect with redirect_pc >= MEM_DEPTH: req_valid<=0, state<=HALT.
  - pc >= MEM_DEPTH with no stall and no redirect: req_valid<=0, state<=HALT. The last word was delivered in that cycle.
- HALT: halted=1, if_valid=0, mem_rw=1, mem_read_address=req_pc. Stall, redirect and load are ignored; only reset exits.
- pc arithmetic is PC_SIZE+1 bits for the >= MEM_DEPTH compare. pc never wraps.
- Reset mid-LOAD/RUN: immediate return to reset outputs; memory is re-cleared via CLEAR.

Decomposition:
- Shared package holds: fetch state encoding (CLEAR/LOAD/RUN/HALT), PC_SIZE, INSTRUCTION_LENGTH and MEM_DEPTH defaults shared with the memory and decode stage, and the RESET_PC constant.
- No sub-module. The load sequencer and fetch datapath stay in one module because they share the memory port mux.

Test Plan:
- Reset, then load 0xA,0xB,0xC with load_last on 0xC -> three writes to addresses 0,1,2 with mem_rw=0 only on those cycles; RUN cycle 1 has if_valid=0; then if_pc/instr = 0/0xA, 1/0xB, 2/0xC.
- load_valid low for 2 cycles mid-load -> mem_rw=1 in the gap cycles, load_count unchanged, no spurious write.
- stall held 3 cycles while if_pc=1 -> if_pc=1, if_instruction=0xB, if_valid=1 and mem_read_address=1 stable throughout; pc=2 resumes after stall drops.
- redirect to 0 together with stall while if_pc=2 -> if_valid=0 that cycle; next cycle if_pc=0, if_instruction=0xA.
- MEM_DEPTH=8, run uninterrupted -> last if_pc=7, next cycle halted=1, if_valid=0; a later redirect is ignored.
- reset_n low mid-RUN -> same cycle if_valid=0, mem_reset_memory=1; after release, CLEAR lasts 1 cycle and load_ready=1.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit, the instruction memory
// and the decode stage.
//   - Default geometry: PC/address width, instruction width, memory depth.
//   - RESET_PC: first fetch address once a program has been loaded.
//   - fetch_state_e: fetch sequencer states.
package instruction_fetch_unit_pkg;

  localparam int unsigned PC_SIZE_DEF            = 10;
  localparam int unsigned INSTRUCTION_LENGTH_DEF = 32;
  localparam int unsigned MEM_DEPTH_DEF          = 100;
  localparam int unsigned RESET_PC_DEF           = 0;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_LOAD,
    ST_RUN,
    ST_HALT
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: sole master of the synchronous-read instruction
// memory. After reset it clears the memory for one cycle, loads a program
// from a host stream through the memory write port, then fetches one word
// per cycle into the IF/ID boundary with stall, redirect and halt support.
// Ports:
//   clock, reset_n            clock, async active-low reset
//   load_valid/data/last      host program stream; load_ready accepts it
//   stall                     downstream holds the current IF word
//   redirect, redirect_pc     branch/jump taken, new fetch target
//   mem_*                     memory address/rw/clear/write-data/read-data
//   if_valid/pc/instruction   IF word towards decode
//   halted                    fetch ran off the end of memory; reset exits
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned PC_SIZE            = PC_SIZE_DEF,
  parameter int unsigned INSTRUCTION_LENGTH = INSTRUCTION_LENGTH_DEF,
  parameter int unsigned MEM_DEPTH          = MEM_DEPTH_DEF,
  parameter int unsigned RESET_PC           = RESET_PC_DEF
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          load_valid,
  input  logic [INSTRUCTION_LENGTH-1:0] load_data,
  input  logic                          load_last,
  output logic                          load_ready,
  input  logic                          stall,
  input  logic                          redirect,
  input  logic [PC_SIZE-1:0]            redirect_pc,
  output logic [PC_SIZE-1:0]            mem_read_address,
  output logic [PC_SIZE-1:0]            mem_write_address,
  output logic                          mem_rw,
  output logic                          mem_reset_memory,
  output logic [INSTRUCTION_LENGTH-1:0] mem_instruction_in,
  input  logic [INSTRUCTION_LENGTH-1:0] mem_instruction_out,
  output logic                          if_valid,
  output logic [PC_SIZE-1:0]            if_pc,
  output logic [INSTRUCTION_LENGTH-1:0] if_instruction,
  output logic                          halted
);

  // pc carries one extra bit so the end-of-memory compare never wraps.
  localparam logic [PC_SIZE:0]   DEPTH_W    = (PC_SIZE+1)'(MEM_DEPTH);
  localparam logic [PC_SIZE:0]   RESET_PC_W = (PC_SIZE+1)'(RESET_PC);
  localparam logic [PC_SIZE:0]   PC_ONE     = (PC_SIZE+1)'(1);
  localparam logic [PC_SIZE-1:0] LC_ONE     = PC_SIZE'(1);
  localparam logic [PC_SIZE-1:0] LAST_IDX   = PC_SIZE'(MEM_DEPTH - 1);

  fetch_state_e      state_q, state_d;
  logic [PC_SIZE:0]   pc_q, pc_d;
  logic [PC_SIZE-1:0] req_pc_q, req_pc_d;
  logic               req_valid_q, req_valid_d;
  logic [PC_SIZE-1:0] load_count_q, load_count_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_CLEAR;
      pc_q         <= RESET_PC_W;
      req_pc_q     <= '0;
      req_valid_q  <= 1'b0;
      load_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      req_valid_q  <= req_valid_d;
      load_count_q <= load_count_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    req_pc_d           = req_pc_q;
    req_valid_d        = req_valid_q;
    load_count_d       = load_count_q;
    mem_read_address   = '0;
    mem_write_address  = '0;
    mem_rw             = 1'b1;
    mem_reset_memory   = 1'b0;
    mem_instruction_in = '0;
    load_ready         = 1'b0;
    if_valid           = 1'b0;
    halted             = 1'b0;

    unique case (state_q)
      ST_CLEAR: begin
        mem_reset_memory = 1'b1;
        state_d          = ST_LOAD;
      end

      ST_LOAD: begin
        load_ready         = 1'b1;
        mem_write_address  = load_count_q;
        mem_instruction_in = load_data;
        // The memory writes on every rw=0 edge, so rw drops only on a
        // real handshake.
        if (load_valid) begin
          mem_rw       = 1'b0;
          load_count_d = load_count_q + LC_ONE;
          if (load_last || (load_count_q == LAST_IDX)) begin
            state_d     = ST_RUN;
            pc_d        = RESET_PC_W;
            req_valid_d = 1'b0;
          end
        end
      end

      ST_RUN: begin
        if_valid = req_valid_q & ~redirect;
        if (redirect) begin
          // Fetch the target now so it appears next cycle: only the
          // squashed word is lost.
          mem_read_address = redirect_pc;
          req_pc_d         = redirect_pc;
          if ({1'b0, redirect_pc} >= DEPTH_W) begin
            req_valid_d = 1'b0;
            state_d     = ST_HALT;
          end else begin
            req_valid_d = 1'b1;
            pc_d        = {1'b0, redirect_pc} + PC_ONE;
          end
        end else if (stall) begin
          // Re-read the held address so the registered read data stays put.
          mem_read_address = req_pc_q;
        end else if (pc_q >= DEPTH_W) begin
          mem_read_address = req_pc_q;
          req_valid_d      = 1'b0;
          state_d          = ST_HALT;
        end else begin
          mem_read_address = pc_q[PC_SIZE-1:0];
          req_pc_d         = pc_q[PC_SIZE-1:0];
          req_valid_d      = 1'b1;
          pc_d             = pc_q + PC_ONE;
        end
      end

      ST_HALT: begin
        halted           = 1'b1;
        mem_read_address = req_pc_q;
      end

      default: state_d = ST_CLEAR;
    endcase
  end

  assign if_pc          = req_pc_q;
  assign if_instruction = mem_instruction_out;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam int unsigned PCW   = 4;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 8;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            load_valid = 1'b0;
  logic [IW-1:0]   load_data = '0;
  logic            load_last = 1'b0;
  logic            load_ready;
  logic            stall = 1'b0;
  logic            redirect = 1'b0;
  logic [PCW-1:0]  redirect_pc = '0;
  logic [PCW-1:0]  mem_read_address, mem_write_address;
  logic            mem_rw, mem_reset_memory;
  logic [IW-1:0]   mem_instruction_in, mem_instruction_out;
  logic            if_valid;
  logic [PCW-1:0]  if_pc;
  logic [IW-1:0]   if_instruction;
  logic            halted;

  instruction_fetch_unit #(
    .PC_SIZE(PCW), .INSTRUCTION_LENGTH(IW), .MEM_DEPTH(DEPTH), .RESET_PC(0)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_rw(mem_rw), .mem_reset_memory(mem_reset_memory),
    .mem_instruction_in(mem_instruction_in), .mem_instruction_out(mem_instruction_out),
    .if_valid(if_valid), .if_pc(if_pc), .if_instruction(if_instruction),
    .halted(halted)
  );

  always #5 clock = ~clock;

  // Instruction memory: synchronous clear, write on rw=0, registered read.
  logic [IW-1:0] mem [0:(1<<PCW)-1];
  always @(posedge clock) begin
    if (mem_reset_memory) begin
      for (int i = 0; i < (1 << PCW); i++) mem[i] <= '0;
    end else if (!mem_rw) begin
      mem[mem_write_address] <= mem_instruction_in;
    end
    mem_instruction_out <= mem[mem_read_address];
  end

  typedef struct {
    int unsigned   addr;
    logic [IW-1:0] data;
  } exp_t;

  exp_t wq[$];
  exp_t fq[$];
  int checks = 0;
  int errors = 0;

  // Reference model: program image plus the fetch stream position.
  logic [IW-1:0] prog [0:(1<<PCW)-1];
  bit            m_pres_valid;
  int unsigned   m_pres_addr;
  int unsigned   m_nf;
  bit            m_halted;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: pops the scoreboards whenever the DUT writes or hands over a word.
  bit            hold_prev = 0;
  logic [PCW-1:0] hold_pc;
  logic [IW-1:0]  hold_instr;
  always @(negedge clock) begin
    if (!reset_n) begin
      hold_prev = 0;
    end else begin
      if (!mem_rw) begin
        if (wq.size() == 0) begin
          chk("spurious_write_rw", {63'd0, mem_rw}, 64'd1);
        end else begin
          exp_t e;
          e = wq.pop_front();
          chk("write_addr", 64'(mem_write_address), 64'(e.addr));
          chk("write_data", 64'(mem_instruction_in), 64'(e.data));
        end
      end else if (wq.size() != 0) begin
        void'(wq.pop_front());
        chk("missing_write_rw", {63'd0, mem_rw}, 64'd0);
      end

      if (if_valid && !stall) begin
        if (fq.size() == 0) begin
          chk("unexpected_fetch_valid", {63'd0, if_valid}, 64'd0);
        end else begin
          exp_t e;
          e = fq.pop_front();
          chk("fetch_pc", 64'(if_pc), 64'(e.addr));
          chk("fetch_instr", 64'(if_instruction), 64'(e.data));
        end
      end else if (fq.size() != 0) begin
        void'(fq.pop_front());
        chk("missing_fetch_valid", {63'd0, if_valid & ~stall}, 64'd1);
      end

      if (redirect) chk("redirect_squash", {63'd0, if_valid}, 64'd0);

      if (hold_prev) begin
        chk("stall_hold_pc", 64'(if_pc), 64'(hold_pc));
        chk("stall_hold_instr", 64'(if_instruction), 64'(hold_instr));
        if (!redirect) chk("stall_hold_valid", {63'd0, if_valid}, 64'd1);
      end
      if (if_valid && stall) begin
        chk("stall_read_addr", 64'(mem_read_address), 64'(if_pc));
        hold_prev  = 1;
        hold_pc    = if_pc;
        hold_instr = if_instruction;
      end else begin
        hold_prev = 0;
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    load_valid = 1'b0; load_last = 1'b0; load_data = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    wq.delete();
    fq.delete();
    for (int i = 0; i < (1 << PCW); i++) prog[i] = '0;
    tick();
    tick();
    chk("rst_mem_reset", {63'd0, mem_reset_memory}, 64'd1);
    chk("rst_mem_rw", {63'd0, mem_rw}, 64'd1);
    chk("rst_load_ready", {63'd0, load_ready}, 64'd0);
    chk("rst_if_valid", {63'd0, if_valid}, 64'd0);
    chk("rst_if_pc", 64'(if_pc), 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_rd_addr", 64'(mem_read_address), 64'd0);
    chk("rst_wr_addr", 64'(mem_write_address), 64'd0);
    chk("rst_wr_data", 64'(mem_instruction_in), 64'd0);
    reset_n = 1'b1;
    #1;
    chk("clear_mem_reset", {63'd0, mem_reset_memory}, 64'd1);
    chk("clear_load_ready", {63'd0, load_ready}, 64'd0);
    tick();
    chk("load_mem_reset", {63'd0, mem_reset_memory}, 64'd0);
    chk("load_ready_up", {63'd0, load_ready}, 64'd1);
  endtask

  // Loads words; gaps > 0 inserts idle cycles before a word.
  task automatic do_load(input int unsigned n, input bit use_last, input bit directed,
                         input int unsigned gap_at);
    for (int unsigned i = 0; i < n; i++) begin
      int unsigned gaps;
      gaps = directed ? ((i == gap_at) ? 2 : 0) : $urandom_range(0, 2);
      for (int unsigned g = 0; g < gaps; g++) begin
        load_valid = 1'b0;
        load_data  = $urandom;
        #1;
        chk("load_gap_rw", {63'd0, mem_rw}, 64'd1);
        tick();
      end
      load_valid = 1'b1;
      load_data  = directed ? (IW'(32'hA) + IW'(i)) : IW'($urandom);
      load_last  = use_last && (i == n - 1);
      prog[i]    = load_data;
      wq.push_back('{i, load_data});
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    m_pres_valid = 0;
    m_pres_addr  = 0;
    m_nf         = 0;
    m_halted     = 0;
  endtask

  // mode 0: free run; 1: directed stall/redirect; 2: random.
  task automatic do_run(input int mode, input int reset_at);
    int unsigned stall_cnt = 0;
    bit          did_redir = 0;
    int unsigned hc = 0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      bit st, rd;
      int unsigned tgt;
      if (cyc == reset_at) begin
        reset_n = 1'b0;
        #1;
        chk("midrun_rst_if_valid", {63'd0, if_valid}, 64'd0);
        chk("midrun_rst_mem_reset", {63'd0, mem_reset_memory}, 64'd1);
        wq.delete();
        fq.delete();
        return;
      end
      if (m_halted) begin
        stall       = $urandom_range(0, 1);
        redirect    = $urandom_range(0, 1);
        redirect_pc = PCW'($urandom_range(0, 7));
        #1;
        chk("halt_halted", {63'd0, halted}, 64'd1);
        chk("halt_if_valid", {63'd0, if_valid}, 64'd0);
        chk("halt_rw", {63'd0, mem_rw}, 64'd1);
        tick();
        hc++;
        if (hc >= 3) break;
        continue;
      end
      st = 0; rd = 0; tgt = 0;
      if (mode == 1) begin
        if (m_pres_valid && m_pres_addr == 1 && stall_cnt < 3) begin
          st = 1; stall_cnt++;
        end else if (m_pres_valid && m_pres_addr == 2 && !did_redir) begin
          st = 1; rd = 1; tgt = 0; did_redir = 1;
        end
      end else if (mode == 2 && cyc < 60) begin
        st  = ($urandom_range(0, 9) < 3);
        rd  = ($urandom_range(0, 99) < 12);
        tgt = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH, 15) : $urandom_range(0, DEPTH - 1);
      end
      stall       = st;
      redirect    = rd;
      redirect_pc = PCW'(tgt);
      if (rd) begin
        if (tgt >= DEPTH) begin
          m_halted = 1; m_pres_valid = 0;
        end else begin
          m_pres_valid = 1; m_pres_addr = tgt; m_nf = tgt + 1;
        end
      end else if (!st) begin
        if (m_pres_valid) fq.push_back('{m_pres_addr, prog[m_pres_addr]});
        if (m_nf >= DEPTH) begin
          m_halted = 1; m_pres_valid = 0;
        end else begin
          m_pres_valid = 1; m_pres_addr = m_nf; m_nf++;
        end
      end
      tick();
    end
    stall = 1'b0;
    redirect = 1'b0;
    if (!m_halted) begin
      errors++;
      $display("FAIL halt_timeout actual=running expected=halted t=%0t", $time);
    end
  endtask

  initial begin
    tick();
    // Directed: A,B,C with gap mid-load, free run to halt.
    do_reset();
    do_load(3, 1, 1, 1);
    do_run(0, -1);
    // Directed: stall on pc 1, redirect+stall on pc 2.
    do_reset();
    do_load(3, 1, 1, 99);
    do_run(1, -1);
    // Fill the whole memory without load_last.
    do_reset();
    do_load(DEPTH, 0, 0, 0);
    do_run(2, -1);
    // Reset in the middle of RUN.
    do_reset();
    do_load(5, 1, 0, 0);
    do_run(2, 4);
    for (int ep = 0; ep < 10; ep++) begin
      int unsigned n;
      do_reset();
      n = $urandom_range(1, DEPTH);
      do_load(n, (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1)), 0, 0);
      do_run(2, -1);
    end
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
